// File: rtl/adc_snap_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_snap_capture : pre/post-trigger snapshot of a dual-channel ADC stream
// Optional level trigger on channel 0: define ADC_SNAP_LEVEL_TRIG_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module adc_snap_capture #(
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 64
) (
  input  logic        clk_240,
  input  logic        rst,
  input  logic [15:0] ch_adc0_data,
  input  logic [15:0] ch_adc1_data,
  input  logic        link_ok,
  input  logic        arm,
  input  logic        trig,
  input  logic [15:0] level_thr,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [1:0]  state,
  output logic        link_err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_PRE       = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] C_POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic              trig_hit;
  logic              wr_en;
  logic              arm_ok;

`ifdef ADC_SNAP_LEVEL_TRIG_EN
  // 17-bit magnitude so that |-32768| = 32768 is representable
  logic [16:0] ch0_mag;
  always_comb begin
    ch0_mag = ch_adc0_data[15] ? (17'd0 - {1'b1, ch_adc0_data})
                               : {1'b0, ch_adc0_data};
  end
  assign trig_hit = trig | (ch0_mag > {1'b0, level_thr});
`else
  logic unused_level_thr;
  assign unused_level_thr = ^level_thr;
  assign trig_hit = trig;
`endif

  assign arm_ok = arm & link_ok;
  assign wr_en  = ((state == S_ARMED) || (state == S_POST)) && link_ok;

  always_ff @(posedge clk_240) begin
    if (wr_en && !rst) begin
      mem[wptr] <= {ch_adc1_data, ch_adc0_data};
    end
  end

  always_ff @(posedge clk_240) begin
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      link_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (wr_en) begin
        wptr <= wptr + C_ONE;
      end
      case (state)
        S_IDLE: begin
          if (arm_ok) begin
            state    <= S_ARMED;
            pre_cnt  <= '0;
            link_err <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!link_ok) begin
            state    <= S_IDLE;
            link_err <= 1'b1;
          end else if (trig_hit && (pre_cnt == C_PRE)) begin
            // Trigger sample is written this cycle and counts as the first post sample
            if (C_POST_LAST == '0) begin
              state  <= S_DONE;
              rd_ptr <= wptr + C_ONE;
            end else begin
              state    <= S_POST;
              post_cnt <= C_ONE;
            end
          end else if (pre_cnt != C_PRE) begin
            pre_cnt <= pre_cnt + C_ONE;
          end
        end
        S_POST: begin
          if (!link_ok) begin
            state    <= S_IDLE;
            link_err <= 1'b1;
          end else begin
            post_cnt <= post_cnt + C_ONE;
            if (post_cnt == C_POST_LAST) begin
              state  <= S_DONE;
              rd_ptr <= wptr + C_ONE;
            end
          end
        end
        S_DONE: begin
          if (arm_ok) begin
            state    <= S_ARMED;
            pre_cnt  <= '0;
            link_err <= 1'b0;
          end else if (rd_en) begin
            rd_data  <= mem[rd_ptr];
            rd_valid <= 1'b1;
            rd_ptr   <= rd_ptr + C_ONE;
            // wptr is frozen in DONE and marks the oldest sample; the slot before it is the last
            if (rd_ptr == (wptr - C_ONE)) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/adc_snap_capture.md
ADC_SNAP_CAPTURE -- requirements
Module: adc_snap_capture

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning buffer depth DEPTH = 2^ADDR_W sample pairs.
REQ-002 SHALL have parameter PRE_TRIG, default 64, meaning samples kept before the trigger; legal range 1..DEPTH-1.
REQ-003 SHALL have port clk_240  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports ch_adc0_data / ch_adc1_data  in  16 each  ADC channel samples, one new pair per clk_240 cycle.
REQ-006 SHALL have port link_ok  in  1  high while the JESD link is synchronised (sync_n deasserted).
REQ-007 SHALL have ports arm and trig  in  1 each  single-cycle strobes.
REQ-008 SHALL have port level_thr  in  16  unsigned magnitude threshold for the level trigger.
REQ-009 SHALL have port rd_en  in  1  readout strobe from the SPI side.
REQ-010 SHALL have port rd_data  out  32  captured pair {ch1,ch0}.
REQ-011 SHALL have port rd_valid  out  1  qualifies rd_data.
REQ-012 SHALL have port state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-013 SHALL have port link_err  out  1  sticky flag: capture aborted by link loss.

Function
REQ-014 SHALL store {ch_adc1_data, ch_adc0_data} at wptr in a DEPTH x 32 single-clock RAM each cycle in ARMED or POST while link_ok=1; wptr then increments modulo DEPTH.
REQ-015 SHALL go IDLE->ARMED on arm with link_ok=1: clear pre_cnt and link_err; a simultaneous trig is ignored.
REQ-016 SHALL, in ARMED, increment pre_cnt on every write, saturating at PRE_TRIG.
REQ-017 SHALL ignore trig in ARMED while pre_cnt<PRE_TRIG; with pre_cnt=PRE_TRIG, trig moves to POST and the sample written that cycle is the trigger sample.
REQ-018 SHALL, in POST, write DEPTH-PRE_TRIG samples counting the trigger sample, then enter DONE; the capture pointer then equals wptr, the oldest sample.
REQ-019 SHALL, on link_ok=0 in ARMED or POST, return to IDLE, set link_err, and stop writing that cycle; link_err clears only on the next accepted arm or reset.
REQ-020 SHALL, in DONE, read the RAM at rd_ptr on rd_en, start rd_ptr at the capture pointer, and increment it modulo DEPTH per rd_en.
REQ-021 SHALL drive rd_valid high exactly one cycle after each accepted rd_en, with rd_data valid in that same cycle.
REQ-022 SHALL enter IDLE after the DEPTH-th rd_en; later rd_en is ignored.
REQ-023 SHALL ignore rd_en outside DONE: rd_valid=0 and rd_data holds.
REQ-024 SHALL restart capture on arm in DONE, abandoning the readout; arm in ARMED or POST is ignored.
REQ-025 SHALL present rd_data in trigger order: read index PRE_TRIG, counted from 0, is the trigger sample.

Reset
REQ-026 SHALL, on rst=1 at a clk_240 edge, set state=IDLE, wptr=0, rd_ptr=0, pre_cnt=0, post counter=0, rd_valid=0, rd_data=0 and link_err=0; rst overrides all other inputs.
REQ-027 SHALL NOT clear RAM contents on reset.

Configuration
REQ-028 SHALL, with macro ADC_SNAP_LEVEL_TRIG_EN defined, also trigger when |signed ch_adc0_data| > level_thr, ORed with trig under the same REQ-017 rules; |-32768| = 32768.
REQ-029 SHALL, without ADC_SNAP_LEVEL_TRIG_EN, ignore level_thr, keep the port, and accept only the trig port as a trigger.

Verification
REQ-030 SHALL cover: ADDR_W=4, PRE_TRIG=4, ch0=counter from 0, ch1=~ch0, arm, trig 10 cycles later -> DONE after 12 post writes; 16 reads return a contiguous counter sequence, read index 4 = trigger-cycle value.
REQ-031 SHALL cover: trig 2 cycles after arm with PRE_TRIG=4 -> ignored, state stays 1; second trig at 6 cycles -> state 2.
REQ-032 SHALL cover: link_ok dropped for 1 cycle in POST -> state 0 and link_err=1 next cycle; next arm clears link_err.
REQ-033 SHALL cover: rd_en in IDLE -> rd_valid stays 0; in DONE, rd_en on 3 consecutive cycles -> 3 consecutive rd_valid pulses 1 cycle later.
REQ-034 SHALL cover: with ADC_SNAP_LEVEL_TRIG_EN, level_thr=1000, ch0=-1001 after pre-fill -> enters POST; ch0=1000 -> no trigger; without the macro, same stimulus -> no trigger.
REQ-035 SHALL cover: rst asserted mid-POST -> all outputs at reset values next cycle; arm then captures normally.
